// File: rtl/elevator_pkg.sv
// Shared elevator constants: default floor count, debounce length
// and the width helper for call counters.
package elevator_pkg;

  localparam int DEF_LEVELS   = 8;
  localparam int DEF_DEBOUNCE = 4;

  function automatic int count_w(input int levels);
    return $clog2(3 * levels + 1);
  endfunction

endpackage

// File: rtl/call_debounce.sv
// One button: counter-based debounce of a raw level plus a
// registered single-cycle pulse on each accepted press.
module call_debounce
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          prev_q, prev_d;
  logic          press_q, press_d;

  // Flip on the Nth disagreeing sample; any agreement restarts.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (raw != level_q) begin
      if (cnt_q == LAST) begin
        level_d = raw;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    prev_d  = level_q;
    press_d = level_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/call_register.sv
// Elevator call latches: debounced cabin/hall buttons set calls,
// the controller clears them; registered summary outputs.
module call_register
  import elevator_pkg::*;
#(
  parameter int LEVELS          = DEF_LEVELS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LEVELS-1:0]            btn_in,
  input  logic [LEVELS-1:0]            btn_up_out,
  input  logic [LEVELS-1:0]            btn_down_out,
  input  logic                         block_in,
  input  logic                         block_out,
  input  logic [LEVELS-1:0]            inactivate_in_levels,
  input  logic [LEVELS-1:0]            inactivate_out_up_levels,
  input  logic [LEVELS-1:0]            inactivate_out_down_levels,
  output logic [LEVELS-1:0]            active_in_levels,
  output logic [LEVELS-1:0]            active_out_up_levels,
  output logic [LEVELS-1:0]            active_out_down_levels,
  output logic                         any_request,
  output logic [count_w(LEVELS)-1:0]   pending_count
);

  localparam int N  = 3 * LEVELS;
  localparam int CW = count_w(LEVELS);

  logic [N-1:0]  raw, press, unused_level, blk, inact;
  logic [N-1:0]  active_q, active_d;
  logic [CW-1:0] count_q, count_d;
  logic          any_q, any_d;

  assign raw   = {btn_down_out, btn_up_out, btn_in};
  assign inact = {inactivate_out_down_levels,
                  inactivate_out_up_levels,
                  inactivate_in_levels};
  assign blk   = {{(2 * LEVELS){block_out}}, {LEVELS{block_in}}};

  for (genvar i = 0; i < N; i++) begin : g_db
    call_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[i]),
      .level (unused_level[i]),
      .press (press[i])
    );
  end

  // Clear beats set; top-floor up and ground-floor down don't exist.
  always_comb begin
    active_d = (active_q | (press & ~blk)) & ~inact;
    active_d[2*LEVELS-1] = 1'b0;
    active_d[2*LEVELS]   = 1'b0;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < N; i++) begin
      count_d = count_d + CW'(active_q[i]);
    end
    any_d = |active_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      active_q <= '0;
      count_q  <= '0;
      any_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      count_q  <= count_d;
      any_q    <= any_d;
    end
  end

  assign active_in_levels       = active_q[LEVELS-1:0];
  assign active_out_up_levels   = active_q[2*LEVELS-1:LEVELS];
  assign active_out_down_levels = active_q[N-1:2*LEVELS];
  assign any_request            = any_q;
  assign pending_count          = count_q;

endmodule
